// File: rtl/ltv_detector.sv
// Local-road vehicle request front end: debounce loop sensor, queue vehicles, watch lights.
// Latency: SENSE->QCOUNT/LTV = DEB_CYCLES+2 CLK edges; TICK depart and FAULT take effect 1 edge later.
// Backpressure: none; arrivals beyond 2^QW-1 are dropped, TICK without a queued vehicle is ignored.
//
// Ports:
//   CLK     board clock, all state on posedge
//   RST     synchronous active-high reset
//   SENSE   raw asynchronous loop sensor (1 = vehicle over loop)
//   TICK    one-CLK pulse per controller slow-clock period
//   H, L    highway / local light fed back from controller, [2]=R [1]=Y [0]=G
//   LTV     local vehicle waiting (registered, == QCOUNT != 0)
//   QCOUNT  queued local vehicles, saturating
//   FAULT   sticky illegal light combination flag

module ltv_detector #(
    parameter int DEB_CYCLES = 4,
    parameter int QW         = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          SENSE,
    input  logic          TICK,
    input  logic [2:0]    H,
    input  logic [2:0]    L,
    output logic          LTV,
    output logic [QW-1:0] QCOUNT,
    output logic          FAULT
);

    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    // The counter is incremented as it is compared, so the state change
    // happens while it still holds DEB_CYCLES-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [QW-1:0] QMAX     = {QW{1'b1}};
    localparam logic [QW-1:0] QONE     = QW'(1);

    localparam logic [2:0] LIGHT_RED   = 3'b100;
    localparam logic [2:0] LIGHT_GREEN = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        PRESENT,
        RELEASING
    } deb_state_t;

    logic          sync1;
    logic          sync2;
    deb_state_t    state;
    logic [CW-1:0] cnt;
    logic          arrive;
    logic          depart;
    logic [QW-1:0] qnext;
    logic          illegal;

    // Two-flop synchronizer; sync2 is the only version of SENSE used below.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= SENSE;
            sync2 <= sync1;
        end
    end

    // Debounce FSM. The debounced level is low in IDLE/ARMING and high in
    // PRESENT/RELEASING; arrive pulses on the accepted rising transition.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            arrive <= 1'b0;
        end else begin
            arrive <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync2) begin
                        state <= ARMING;
                        cnt   <= CNT_ONE;
                    end
                end
                ARMING: begin
                    if (!sync2) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= PRESENT;
                        cnt    <= '0;
                        arrive <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESENT: begin
                    if (!sync2) begin
                        state <= RELEASING;
                        cnt   <= CNT_ONE;
                    end
                end
                RELEASING: begin
                    if (sync2) begin
                        state <= PRESENT;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // One vehicle leaves per slow tick while the local light is green.
    assign depart = TICK && (L == LIGHT_GREEN) && (QCOUNT != '0);

    // Simultaneous arrive and depart cancel out; a saturated arrival is lost.
    always_comb begin
        qnext = QCOUNT;
        if (arrive && !depart) begin
            if (QCOUNT != QMAX) begin
                qnext = QCOUNT + QONE;
            end
        end else if (depart && !arrive) begin
            qnext = QCOUNT - QONE;
        end
    end

    // LTV is derived from the next count so it moves on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            QCOUNT <= '0;
            LTV    <= 1'b0;
        end else begin
            QCOUNT <= qnext;
            LTV    <= (qnext != '0);
        end
    end

    // Legal only if each light is one-hot and at least one approach is red.
    assign illegal = !$onehot(H) || !$onehot(L) ||
                     ((H != LIGHT_RED) && (L != LIGHT_RED));

    always_ff @(posedge CLK) begin
        if (RST) begin
            FAULT <= 1'b0;
        end else if (illegal) begin
            FAULT <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ltv_detector.sv
// Testbench for ltv_detector: directed scenarios plus randomized traffic against a reference model.
// Latency: model tracks the DUT edge by edge; outputs compared every cycle on the falling edge.
// Backpressure: not applicable; bench drives all inputs freely.

module tb_ltv_detector;

    localparam int DEB = 4;
    localparam int QW  = 4;
    localparam int QMAXI = (1 << QW) - 1;

    logic          CLK;
    logic          RST;
    logic          SENSE;
    logic          TICK;
    logic [2:0]    H;
    logic [2:0]    L;
    logic          LTV;
    logic [QW-1:0] QCOUNT;
    logic          FAULT;

    int n_cmp = 0;
    int n_err = 0;

    ltv_detector #(.DEB_CYCLES(DEB), .QW(QW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SENSE  (SENSE),
        .TICK   (TICK),
        .H      (H),
        .L      (L),
        .LTV    (LTV),
        .QCOUNT (QCOUNT),
        .FAULT  (FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: SENSE delayed two edges, debounced level flips once a
    // run of DEB consecutive samples disagrees with it, queue as an integer.
    bit m_sh1, m_sh2;   // SENSE history (1 and 2 edges old)
    bit m_level;
    int m_run;
    bit m_arrive;
    int m_q;
    bit m_fault;

    function automatic bit lights_bad(input logic [2:0] h, input logic [2:0] l);
        return ($countones(h) != 1) || ($countones(l) != 1) ||
               ((h != 3'b100) && (l != 3'b100));
    endfunction

    always @(posedge CLK) begin
        bit s;
        bit dep;
        bit new_arrive;
        if (RST) begin
            m_sh1 = 0; m_sh2 = 0; m_level = 0; m_run = 0;
            m_arrive = 0; m_q = 0; m_fault = 0;
        end else begin
            s = m_sh2;
            m_sh2 = m_sh1;
            m_sh1 = SENSE;
            new_arrive = 0;
            if (s != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = s;
                    m_run = 0;
                    new_arrive = s;
                end
            end else begin
                m_run = 0;
            end
            dep = TICK && (L == 3'b001) && (m_q != 0);
            if (m_arrive && !dep && m_q < QMAXI) m_q++;
            else if (dep && !m_arrive) m_q--;
            m_arrive = new_arrive;
            if (lights_bad(H, L)) m_fault = 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance n cycles; inputs are held, outputs compared to model on negedge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("model_qcount", int'(QCOUNT), m_q);
            check("model_ltv", int'(LTV), int'(m_q != 0));
            check("model_fault", int'(FAULT), int'(m_fault));
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        run(2);
        RST = 1'b0;
    endtask

    task automatic vehicle();
        SENSE = 1'b1;
        run(8);
        SENSE = 1'b0;
        run(8);
    endtask

    task automatic one_tick();
        TICK = 1'b1;
        run(1);
        TICK = 1'b0;
    endtask

    initial begin
        int hold;
        int qbefore;
        RST = 1'b1; SENSE = 1'b0; TICK = 1'b0; H = 3'b001; L = 3'b100;
        @(negedge CLK);

        // Reset and idle
        do_reset();
        check("rst_qcount", int'(QCOUNT), 0);
        check("rst_ltv", int'(LTV), 0);
        check("rst_fault", int'(FAULT), 0);
        run(100);
        check("idle_qcount", int'(QCOUNT), 0);

        // Short pulse rejected
        SENSE = 1'b1; run(3); SENSE = 1'b0; run(10);
        check("short_pulse", int'(QCOUNT), 0);

        // Exact arrival latency: count lands 6 edges after first high sample
        SENSE = 1'b1;
        run(6);
        check("lat_before", int'(QCOUNT), 0);
        run(1);
        check("lat_qcount", int'(QCOUNT), 1);
        check("lat_ltv", int'(LTV), 1);

        // 2-cycle low glitch while present: no extra count
        run(4);
        SENSE = 1'b0; run(2); SENSE = 1'b1; run(12);
        check("glitch_qcount", int'(QCOUNT), 1);
        SENSE = 1'b0; run(10);

        // Queue and drain
        do_reset();
        for (int v = 0; v < 3; v++) vehicle();
        check("queue3", int'(QCOUNT), 3);
        H = 3'b100; L = 3'b001; run(1);
        one_tick(); check("drain1", int'(QCOUNT), 2); check("drain1_ltv", int'(LTV), 1);
        run(3);
        one_tick(); check("drain2", int'(QCOUNT), 1);
        run(3);
        one_tick(); check("drain3", int'(QCOUNT), 0); check("drain3_ltv", int'(LTV), 0);
        run(3);
        one_tick(); check("drain_empty", int'(QCOUNT), 0);
        check("drain_nofault", int'(FAULT), 0);

        // Arrival coinciding with a valid depart tick
        H = 3'b001; L = 3'b100; run(1);
        vehicle(); vehicle();
        H = 3'b100; L = 3'b001;
        qbefore = int'(QCOUNT);
        SENSE = 1'b1;
        run(6);
        TICK = 1'b1; run(1); TICK = 1'b0;
        check("simul_qcount", int'(QCOUNT), qbefore);
        SENSE = 1'b0; run(8);

        // Saturation: 17 arrivals
        H = 3'b001; L = 3'b100;
        do_reset();
        for (int v = 0; v < 17; v++) vehicle();
        check("saturate", int'(QCOUNT), 15);

        // Fault: both green for one cycle, then sticky
        H = 3'b001; L = 3'b001; run(1);
        check("fault_set", int'(FAULT), 1);
        L = 3'b100; run(3);
        check("fault_sticky", int'(FAULT), 1);
        check("fault_no_q_effect", int'(QCOUNT), 15);
        do_reset();
        check("fault_rst", int'(FAULT), 0);
        H = 3'b011; run(1);
        check("fault_h_not_onehot", int'(FAULT), 1);
        H = 3'b001;
        do_reset();
        check("fault_rst2", int'(FAULT), 0);

        // Reset mid-run with SENSE held high
        for (int v = 0; v < 5; v++) vehicle();
        check("mid_q5", int'(QCOUNT), 5);
        SENSE = 1'b1; run(4);
        RST = 1'b1; run(1); RST = 1'b0;
        check("mid_rst_q", int'(QCOUNT), 0);
        check("mid_rst_ltv", int'(LTV), 0);
        check("mid_rst_fault", int'(FAULT), 0);
        run(6);
        check("mid_requal_before", int'(QCOUNT), 0);
        run(1);
        check("mid_requal", int'(QCOUNT), 1);
        SENSE = 1'b0; run(8);

        // Randomized traffic
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                SENSE = ~SENSE;
                hold = $urandom_range(1, 9);
            end
            hold--;
            TICK = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 45) begin H = 3'b100; L = 3'b001; end
                else if (r < 92) begin H = 3'b001; L = 3'b100; end
                else begin H = 3'($urandom); L = 3'($urandom); end
            end
            RST = ($urandom_range(0, 299) == 0);
            run(1);
        end
        RST = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
